// File: rtl/vacc_dbuf.sv
// Double-buffered vector accumulator: sums ACC_LEN samples per element and
// writes each sum into the frame's bank; two read ports fetch from either bank.
module vacc_dbuf #(
    parameter int INPUT_WIDTH   = 4,
    parameter int ACC_LEN_BITS  = 8,
    parameter int VECTOR_LENGTH = 32,
    localparam int VLB          = $clog2(VECTOR_LENGTH),
    localparam int ACC_WIDTH    = INPUT_WIDTH + ACC_LEN_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync,
    input  logic [INPUT_WIDTH-1:0] din,
    input  logic                 buf_sel,
    input  logic [VLB-1:0]       ant_sel_a,
    input  logic [VLB-1:0]       ant_sel_b,
    output logic [ACC_WIDTH-1:0] dout_a,
    output logic [ACC_WIDTH-1:0] dout_b
);
    localparam int CTR_W = ACC_LEN_BITS + VLB;
    localparam int AW    = VLB + 1;
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'((2 ** ACC_LEN_BITS) * VECTOR_LENGTH - 1);

    logic [CTR_W-1:0]        ctr;
    logic                    active_bank;
    logic [ACC_LEN_BITS-1:0] sample_index;
    logic [VLB-1:0]          vec_index;
    logic                    last;
    logic [ACC_WIDTH-1:0]    din_ext;

    assign sample_index = ctr[ACC_LEN_BITS-1:0];
    assign vec_index    = ctr[CTR_W-1:ACC_LEN_BITS];
    assign last         = (sample_index == '1) || sync;
    assign din_ext      = {{ACC_LEN_BITS{din[INPUT_WIDTH-1]}}, din};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctr         <= '0;
            active_bank <= 1'b0;
        end else if (sync) begin
            ctr         <= '0;
            active_bank <= 1'b0;
        end else if (ctr == CTR_MAX) begin
            ctr         <= '0;
            active_bank <= ~active_bank;
        end else begin
            ctr <= ctr + 1'b1;
        end
    end

    // Stage 1 registers the sample, stage 2 accumulates, stage 3 feeds the write port.
    logic [ACC_WIDTH-1:0]   din_r, acc, sum, wr_data;
    logic                   last_r, valid, we;
    logic [2:0][VLB-1:0]    vec_pipe;
    logic [2:0]             bank_pipe;
    logic [AW-1:0]          wr_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_r     <= '0;
            last_r    <= 1'b0;
            acc       <= '0;
            sum       <= '0;
            valid     <= 1'b0;
            wr_data   <= '0;
            we        <= 1'b0;
            vec_pipe  <= '0;
            bank_pipe <= '0;
        end else begin
            din_r     <= din_ext;
            last_r    <= last;
            sum       <= acc + din_r;
            valid     <= last_r;
            acc       <= last_r ? '0 : acc + din_r;
            wr_data   <= sum;
            we        <= valid;
            vec_pipe  <= {vec_pipe[1:0], vec_index};
            bank_pipe <= {bank_pipe[1:0], active_bank};
        end
    end

    assign wr_addr = {bank_pipe[2], vec_pipe[2]};

    // Two copies of the same storage so each read port gets its own RAM.
    logic [ACC_WIDTH-1:0] ram_a [2**AW];
    logic [ACC_WIDTH-1:0] ram_b [2**AW];
    logic [ACC_WIDTH-1:0] q_a, q_b;

    always_ff @(posedge clk) begin
        if (we) begin
            ram_a[wr_addr] <= wr_data;
            ram_b[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_a    <= '0;
            q_b    <= '0;
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            q_a    <= ram_a[{buf_sel, ant_sel_a}];
            q_b    <= ram_b[{buf_sel, ant_sel_b}];
            dout_a <= q_a;
            dout_b <= q_b;
        end
    end
endmodule

// File: tb/tb_vacc_dbuf.sv
// Bench for vacc_dbuf: directed frames plus random traffic, checked against an
// event-level model of sums, scheduled writes and delayed reads.
module tb_vacc_dbuf;
    localparam int AL    = 4;
    localparam int FRAME = 16;
    localparam int MAXC  = 4096;

    logic       clk = 1'b0;
    logic       rst_n, sync, buf_sel;
    logic [3:0] din;
    logic [1:0] ant_sel_a, ant_sel_b;
    logic [5:0] dout_a, dout_b;

    always #5 clk = ~clk;

    vacc_dbuf #(.INPUT_WIDTH(4), .ACC_LEN_BITS(2), .VECTOR_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .din(din), .buf_sel(buf_sel),
        .ant_sel_a(ant_sel_a), .ant_sel_b(ant_sel_b), .dout_a(dout_a), .dout_b(dout_b)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // model state: frame position, bank, running sum, RAM image
    int         pos = 0, mbank = 0, msum = 0;
    logic [5:0] mram [8];
    bit         mknown [8];
    bit         wr_due [MAXC];
    logic [2:0] wr_a [MAXC];
    logic [5:0] wr_d [MAXC];
    logic [5:0] ea [MAXC], eb [MAXC];
    bit         eak [MAXC], ebk [MAXC];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic commit(input int c);
        if (wr_due[c]) begin
            mram[wr_a[c]]   = wr_d[c];
            mknown[wr_a[c]] = 1'b1;
        end
    endtask

    task automatic tick();
        int c;
        c = cyc;
        if (!rst_n) begin
            commit(c);
            pos = 0; mbank = 0; msum = 0;
            for (int k = 1; k <= 3; k++) wr_due[c+k] = 1'b0;
            for (int k = 1; k <= 2; k++) begin
                ea[c+k] = '0; eak[c+k] = 1'b1;
                eb[c+k] = '0; ebk[c+k] = 1'b1;
            end
        end else begin
            msum = msum + int'($signed(din));
            if ((pos % AL) == AL - 1 || sync) begin
                wr_due[c+3] = 1'b1;
                wr_a[c+3]   = {mbank[0], 2'(pos / AL)};
                wr_d[c+3]   = 6'(msum);
                msum = 0;
            end
            ea[c+2] = mram[{buf_sel, ant_sel_a}]; eak[c+2] = mknown[{buf_sel, ant_sel_a}];
            eb[c+2] = mram[{buf_sel, ant_sel_b}]; ebk[c+2] = mknown[{buf_sel, ant_sel_b}];
            commit(c);
            if (sync) begin
                pos = 0; mbank = 0;
            end else begin
                pos++;
                if (pos == FRAME) begin
                    pos = 0; mbank ^= 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("we", 8'(dut.we), 8'(wr_due[cyc]));
        if (wr_due[cyc]) begin
            chk("wr_addr", 8'(dut.wr_addr), 8'(wr_a[cyc]));
            chk("wr_data", 8'(dut.wr_data), 8'(wr_d[cyc]));
        end
        if (eak[cyc]) chk("dout_a", 8'(dout_a), 8'(ea[cyc]));
        if (ebk[cyc]) chk("dout_b", 8'(dout_b), 8'(eb[cyc]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_chk(input logic bs, input logic [1:0] a, input logic [1:0] b,
                            input logic [5:0] xa, input logic [5:0] xb);
        buf_sel = bs; ant_sel_a = a; ant_sel_b = b;
        ticks(2);
        chk("rd_a", 8'(dout_a), 8'(xa));
        chk("rd_b", 8'(dout_b), 8'(xb));
    endtask

    task automatic wr_chk(input string tag, input logic [2:0] a, input logic [5:0] d);
        chk({tag, "_we"}, 8'(dut.we), 8'd1);
        chk({tag, "_addr"}, 8'(dut.wr_addr), 8'(a));
        chk({tag, "_data"}, 8'(dut.wr_data), 8'(d));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin mram[i] = '0; mknown[i] = 1'b0; end
        rst_n = 1'b0; sync = 1'b0; din = 4'd7; buf_sel = 1'b0; ant_sel_a = '0; ant_sel_b = '0;

        // reset with a nonzero sample present
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_dout_a", 8'(dout_a), 8'd0);
            chk("rst_dout_b", 8'(dout_b), 8'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("rel_dout_a", 8'(dout_a), 8'd0);
        chk("rel_we", 8'(dut.we), 8'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rel_we", 8'(dut.we), 8'd0);
        end

        // constant frames and bank alternation
        sync = 1'b1; din = 4'd0; tick();
        sync = 1'b0; din = 4'd1; ticks(16);
        din = 4'd2;
        ticks(2);  wr_chk("f1_last", 3'b011, 6'd4);
        ticks(4);  wr_chk("f2_first", 3'b100, 6'd8);
        ticks(10);
        din = 4'd0;
        ticks(3);
        read_chk(1'b0, 2'd2, 2'd3, 6'd4, 6'd4);
        read_chk(1'b1, 2'd0, 2'd1, 6'd8, 6'd8);

        // signed extremes
        sync = 1'b1; din = 4'd0; tick();
        sync = 1'b0; din = 4'b1000; ticks(16);
        din = 4'd7; ticks(4);
        read_chk(1'b0, 2'd0, 2'd1, 6'b100000, 6'b100000);
        read_chk(1'b0, 2'd2, 2'd3, 6'b100000, 6'b100000);
        ticks(8);
        din = 4'd0; ticks(3);
        read_chk(1'b1, 2'd0, 2'd1, 6'd28, 6'd28);
        read_chk(1'b1, 2'd2, 2'd3, 6'd28, 6'd28);

        // sync in the middle of element 1
        sync = 1'b1; din = 4'd0; tick();
        sync = 1'b0; ticks(4);
        din = 4'd3; ticks(2);
        sync = 1'b1; tick();
        sync = 1'b0; din = 4'd1;
        ticks(2); wr_chk("midsync", 3'b001, 6'd9);
        ticks(4); wr_chk("resume", 3'b000, 6'd4);

        // distinct per-element values, read on both ports at once
        sync = 1'b1; din = 4'd0; tick();
        sync = 1'b0;
        for (int e = 0; e < 4; e++) begin
            din = 4'(e + 1);
            ticks(4);
        end
        din = 4'd0; ticks(3);
        read_chk(1'b0, 2'd0, 2'd3, 6'd4, 6'd16);

        // random traffic with occasional sync and reset
        for (int i = 0; i < 400; i++) begin
            din       = 4'($urandom);
            sync      = ($urandom_range(0, 31) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            buf_sel   = 1'($urandom);
            ant_sel_a = 2'($urandom);
            ant_sel_b = 2'($urandom);
            tick();
        end
        rst_n = 1'b1; sync = 1'b0;
        ticks(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vacc_dbuf.md
Name: vacc_dbuf

Overview:
Double-buffered vector accumulator. It sums ACC_LEN consecutive signed samples per vector element for VECTOR_LENGTH elements per frame. Each finished sum is written into one of two RAM banks, and the banks alternate every frame. Two independent read ports let a downstream correlator or readout fetch any element of either bank while the other bank is being filled.

Parameters:
INPUT_WIDTH, 4, signed sample width.
ACC_LEN_BITS, 8, log2 of samples per element; ACC_LEN = 2^ACC_LEN_BITS.
VECTOR_LENGTH, 32, elements per frame; VLB = clog2(VECTOR_LENGTH); ACC_WIDTH = INPUT_WIDTH + ACC_LEN_BITS.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
sync  in  1  frame restart; the next cycle starts element 0, sample 0, bank 0.
din  in  INPUT_WIDTH  two's-complement sample, one per cycle, always consumed.
buf_sel  in  1  bank selected for both read ports.
ant_sel_a  in  VLB  element index for read port A.
ant_sel_b  in  VLB  element index for read port B.
dout_a  out  ACC_WIDTH  accumulated value at {buf_sel, ant_sel_a}.
dout_b  out  ACC_WIDTH  accumulated value at {buf_sel, ant_sel_b}.

Behaviour:
- Frame counter ctr is ACC_LEN_BITS+VLB bits wide; active_bank is 1 bit.
  - When rst_n=0 or sync=1: ctr<=0 and active_bank<=0. rst_n has priority.
  - Otherwise ctr increments. When ctr = ACC_LEN*VECTOR_LENGTH-1 it wraps to 0 and active_bank toggles.
- sample_index = ctr[ACC_LEN_BITS-1:0]; vec_index = ctr[MSBs].
- last = (sample_index == ACC_LEN-1) || sync.
- Accumulator:
  - Sign-extends din to ACC_WIDTH and sums every sample from the cycle after the previous last up to and including the current last cycle.
  - The sum and a valid flag emerge 2 cycles after the last cycle. A fresh sum then begins.
  - Reset empties the accumulator; the first sample after reset starts a new sum.
  - No overflow is possible: a full ACC_LEN sum of INPUT_WIDTH values fits in ACC_WIDTH. Results are never saturated.
- Write path:
  - Sum and valid pass through one more register, for 3 cycles total after the last cycle.
  - vec_index and active_bank are each delayed by exactly 3 cycles to stay aligned with the sum.
  - Write address = {active_bank_d3, vec_index_d3}, VLB+1 bits. Write enable = valid_d3.
  - The write commits at the end of that cycle.
- sync during an element:
  - sync forces last, so the partial sum (including din of the sync cycle) is written at the pre-sync element address and bank, 3 cycles later.
  - Accumulation restarts cleanly.
- Storage:
  - Two identical RAMs of 2^(VLB+1) x ACC_WIDTH words, both written by the same write port.
  - RAM A is read at {buf_sel, ant_sel_a}; RAM B is read at {buf_sel, ant_sel_b}.
  - RAM reads are synchronous (1 cycle), followed by an output register. dout appears 2 cycles after the address is presented.
  - A same-cycle read and write to the same address returns the old data (read-first).
  - RAM contents are not cleared by reset.
- Reset values:
  - ctr=0, active_bank=0.
  - Every valid stage and delay stage is cleared, so no spurious write occurs after reset.
  - dout_a=dout_b=0 until the first read completes after reset.

Test Plan:
All scenarios use INPUT_WIDTH=4, ACC_LEN_BITS=2, VECTOR_LENGTH=4 (ACC_WIDTH=6, 16-cycle frame).
1. Reset: rst_n=0 for 2 cycles with din=7 -> dout_a=dout_b=0 and no write enable for at least 4 cycles after release.
2. Constant frame: pulse sync, then din=1 for 16 cycles.
   - Bank-0 addresses 0..3 each receive 4; each write occurs 3 cycles after its last sample.
   - Then buf_sel=0, ant_sel_a=2 -> dout_a=4 two cycles later.
3. Signed extreme: din=-8 for a full frame -> every element = -32 (6'b100000). With din=7 -> every element = 28.
4. Bank alternation: frame 1 with din=1, then frame 2 with din=2.
   - buf_sel=1 reads 8 on both ports.
   - buf_sel=0 still reads 4.
   - The write address MSB toggles exactly at the frame boundary.
5. Mid-element sync: after 2 samples of element 1 (din=3), assert sync with din=3.
   - 9 is written to bank 0, address 1.
   - The next element-0 sum starts on the following cycle.
6. Dual read: ant_sel_a=0, ant_sel_b=3 with distinct stored values -> both outputs correct on the same cycle, with 2-cycle latency.
